// File: rtl/snapshot_pkg.sv
// Shared types for the snapshot store: the operating-mode encoding seen on the mode input.
package snapshot_pkg;

  typedef enum logic [1:0] {
    MANUAL   = 2'b00,
    RECORD   = 2'b01,
    PLAYBACK = 2'b10,
    CLEAR    = 2'b11
  } mode_t;

endpackage

// File: rtl/tick_divider.sv
// Free-running modulo-DIV counter; tick is high for the one cycle the count sits at DIV-1.
module tick_divider #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntMax);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CntW'(1);
    if (clr) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/snapshot_bank.sv
// Snapshot store: DEPTH slots of WIDTH-bit words with manual, circular-record, playback and
// clear modes; one selected slot is registered onto the LED bank.
module snapshot_bank
  import snapshot_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PLAY_DIV = 50_000_000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  mode_t                        mode,
  input  logic                         store_en,
  input  logic [$clog2(DEPTH)-1:0]     sel,
  input  logic [WIDTH-1:0]             data_in,
  output logic [WIDTH-1:0]             led,
  output logic [$clog2(DEPTH)-1:0]     shown_idx,
  output logic [DEPTH-1:0]             valid,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic [WIDTH*DEPTH-1:0]       stored
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [IW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [IW-1:0]    last_ptr_q, last_ptr_d;
  logic [IW-1:0]    play_ptr_q, play_ptr_d;
  logic [IW-1:0]    disp_idx;
  logic [IW-1:0]    shown_idx_q;
  logic [WIDTH-1:0] led_q, led_d;
  mode_t            prev_mode_q;
  logic             play_entry;
  logic             tick;

  // prev_mode_q resets to MANUAL so staying in PLAYBACK across a reset counts as a fresh entry.
  assign play_entry = (mode == PLAYBACK) && (prev_mode_q != PLAYBACK);

  tick_divider #(
    .DIV (PLAY_DIV)
  ) u_tick_divider (
    .clk   (clk),
    .reset (reset),
    .clr   (play_entry),
    .tick  (tick)
  );

  always_comb begin
    mem_d      = mem_q;
    valid_d    = valid_q;
    wr_ptr_d   = wr_ptr_q;
    last_ptr_d = last_ptr_q;
    play_ptr_d = play_ptr_q;
    disp_idx   = sel;
    unique case (mode)
      MANUAL: begin
        if (store_en) begin
          mem_d[sel]   = data_in;
          valid_d[sel] = 1'b1;
        end
      end
      RECORD: begin
        disp_idx = last_ptr_q;
        if (store_en) begin
          mem_d[wr_ptr_q]   = data_in;
          valid_d[wr_ptr_q] = 1'b1;
          last_ptr_d        = wr_ptr_q;
          wr_ptr_d          = wr_ptr_q + IW'(1);
        end
      end
      PLAYBACK: begin
        disp_idx = play_ptr_q;
        if (play_entry)  play_ptr_d = '0;
        else if (tick)   play_ptr_d = play_ptr_q + IW'(1);
      end
      CLEAR: begin
        for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
        valid_d    = '0;
        wr_ptr_d   = '0;
        last_ptr_d = '0;
      end
      default: ;
    endcase
  end

  // Display samples pre-edge memory, so a fresh write shows up one cycle later.
  assign led_d = valid_q[disp_idx] ? mem_q[disp_idx] : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      valid_q     <= '0;
      wr_ptr_q    <= '0;
      last_ptr_q  <= '0;
      play_ptr_q  <= '0;
      shown_idx_q <= '0;
      led_q       <= '0;
      prev_mode_q <= MANUAL;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      valid_q     <= valid_d;
      wr_ptr_q    <= wr_ptr_d;
      last_ptr_q  <= last_ptr_d;
      play_ptr_q  <= play_ptr_d;
      shown_idx_q <= disp_idx;
      led_q       <= led_d;
      prev_mode_q <= mode;
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) count = count + CW'(valid_q[i]);
  end

  assign full      = (count == CW'(DEPTH));
  assign led       = led_q;
  assign shown_idx = shown_idx_q;
  assign valid     = valid_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stored
    assign stored[g*WIDTH +: WIDTH] = mem_q[g];
  end

endmodule

// File: tb/tb_snapshot_bank.sv
// Bench for snapshot_bank with a 4-cycle playback divider: vector table plus scoreboard queue.
module tb_snapshot_bank;
  import snapshot_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  mode_t       mode;
  logic        store_en;
  logic [1:0]  sel;
  logic [15:0] data_in;
  logic [15:0] led;
  logic [1:0]  shown_idx;
  logic [3:0]  valid;
  logic [2:0]  count;
  logic        full;
  logic [63:0] stored;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rst_n;
    mode_t       mode;
    logic        se;
    logic [1:0]  sel;
    logic [15:0] data;
    logic [15:0] e_led;
    logic [1:0]  e_idx;
    logic [3:0]  e_valid;
    logic [2:0]  e_count;
    logic        e_full;
    logic        chk_st;
    logic [63:0] e_st;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  snapshot_bank #(
    .WIDTH    (16),
    .DEPTH    (4),
    .PLAY_DIV (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .store_en  (store_en),
    .sel       (sel),
    .data_in   (data_in),
    .led       (led),
    .shown_idx (shown_idx),
    .valid     (valid),
    .count     (count),
    .full      (full),
    .stored    (stored)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst_n, input mode_t m, input logic se,
                              input logic [1:0] s, input logic [15:0] d,
                              input logic [15:0] e_led, input logic [1:0] e_idx,
                              input logic [3:0] e_valid, input logic [2:0] e_count,
                              input logic e_full, input logic chk_st, input logic [63:0] e_st);
    vec_t v;
    v.rst_n = rst_n; v.mode = m; v.se = se; v.sel = s; v.data = d;
    v.e_led = e_led; v.e_idx = e_idx; v.e_valid = e_valid; v.e_count = e_count;
    v.e_full = e_full; v.chk_st = chk_st; v.e_st = e_st;
    return v;
  endfunction

  task automatic chk(input string name, input int n, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%h required=%h", name, n, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int n);
    vec_t e;
    @(negedge clk);
    reset    = v.rst_n;
    mode     = v.mode;
    store_en = v.se;
    sel      = v.sel;
    data_in  = v.data;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("led",       n, 64'(led),       64'(e.e_led));
    chk("shown_idx", n, 64'(shown_idx), 64'(e.e_idx));
    chk("valid",     n, 64'(valid),     64'(e.e_valid));
    chk("count",     n, 64'(count),     64'(e.e_count));
    chk("full",      n, 64'(full),      64'(e.e_full));
    if (e.chk_st) chk("stored", n, stored, e.e_st);
  endtask

  initial begin
    logic [15:0] play_word [4];
    int          idx;
    play_word[0] = 16'h0005; play_word[1] = 16'h0002;
    play_word[2] = 16'h0003; play_word[3] = 16'h0004;

    reset = 1'b0; mode = MANUAL; store_en = 1'b0; sel = '0; data_in = '0;

    // Reset held two cycles with a live write strobe.
    tbl.push_back(mk(0, RECORD, 1, 2, 16'hFFFF, 16'h0, 0, 4'b0000, 0, 0, 1, 64'h0));
    tbl.push_back(mk(0, MANUAL, 1, 2, 16'hFFFF, 16'h0, 0, 4'b0000, 0, 0, 1, 64'h0));
    // MANUAL write to slot 2, then look at slot 1.
    tbl.push_back(mk(1, MANUAL, 1, 2, 16'hA5A5, 16'h0,    2, 4'b0100, 1, 0, 1,
                     64'h0000_A5A5_0000_0000));
    tbl.push_back(mk(1, MANUAL, 0, 2, 16'h0,    16'hA5A5, 2, 4'b0100, 1, 0, 0, 64'h0));
    tbl.push_back(mk(1, MANUAL, 0, 1, 16'h0,    16'h0,    1, 4'b0100, 1, 0, 0, 64'h0));
    // RECORD 1..5 wraps into slot 0.
    tbl.push_back(mk(1, RECORD, 1, 1, 16'h0001, 16'h0,    0, 4'b0101, 2, 0, 0, 64'h0));
    tbl.push_back(mk(1, RECORD, 1, 1, 16'h0002, 16'h0001, 0, 4'b0111, 3, 0, 0, 64'h0));
    tbl.push_back(mk(1, RECORD, 1, 1, 16'h0003, 16'h0002, 1, 4'b0111, 3, 0, 0, 64'h0));
    tbl.push_back(mk(1, RECORD, 1, 1, 16'h0004, 16'h0003, 2, 4'b1111, 4, 1, 0, 64'h0));
    tbl.push_back(mk(1, RECORD, 1, 1, 16'h0005, 16'h0004, 3, 4'b1111, 4, 1, 0, 64'h0));
    tbl.push_back(mk(1, RECORD, 0, 1, 16'h0,    16'h0005, 0, 4'b1111, 4, 1, 1,
                     64'h0004_0003_0002_0005));

    // PLAYBACK: entry edge j=0; pointer advances on edges 4,8,12,16, visible one edge later.
    for (int j = 0; j < 18; j++) begin
      idx = (j <= 4) ? 0 : (((j - 1) / 4) % 4);
      tbl.push_back(mk(1, PLAYBACK, logic'(j % 2), 3, 16'hDEAD, play_word[idx], 2'(idx),
                       4'b1111, 4, 1, 1, 64'h0004_0003_0002_0005));
    end

    // CLEAR for one cycle, then RECORD restarts at slot 0.
    tbl.push_back(mk(1, CLEAR,  1, 0, 16'hBEEF, 16'h0005, 0, 4'b0000, 0, 0, 1, 64'h0));
    tbl.push_back(mk(1, RECORD, 1, 2, 16'h00FF, 16'h0,    0, 4'b0001, 1, 0, 1, 64'h00FF));
    tbl.push_back(mk(1, RECORD, 0, 2, 16'h0,    16'h00FF, 0, 4'b0001, 1, 0, 0, 64'h0));

    foreach (tbl[i]) apply(tbl[i], i);

    // Reset in the middle of playback, then stay in PLAYBACK: first advance 4 edges later.
    for (int j = 0; j < 3; j++)
      apply(mk(1, PLAYBACK, 0, 0, 16'h0, 16'h00FF, 0, 4'b0001, 1, 0, 0, 64'h0), 100 + j);
    apply(mk(0, PLAYBACK, 1, 0, 16'h1234, 16'h0, 0, 4'b0000, 0, 0, 1, 64'h0), 103);
    for (int j = 0; j < 6; j++)
      apply(mk(1, PLAYBACK, 0, 0, 16'h0, 16'h0, (j == 5) ? 2'd1 : 2'd0, 4'b0000, 0, 0, 1,
               64'h0), 104 + j);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snapshot_bank.md
# snapshot_bank

- Parametrised snapshot store for the cellular-automaton board design.
- Captures `WIDTH`-bit generation words from the automaton core into `DEPTH` slots and drives one selected slot onto the LED bank.
- Four modes:
  - manual slot writing
  - circular auto-recording, where the newest word overwrites the oldest
  - timed playback through the stored history
  - clear
- Sits between the automaton core's state outputs and the board LEDs/debug bus.

## Interface

Parameters:
- `WIDTH`, 16: bits per snapshot word.
- `DEPTH`, 4: number of slots. Power of two, ≥2.
- `PLAY_DIV`, 50_000_000: clock cycles per playback step. ≥2.

Ports (IW = $clog2(DEPTH), CW = $clog2(DEPTH+1)):
- `clk`, in, 1: the single clock. All logic on its rising edge.
- `reset`, in, 1: synchronous, active-low. Asserted when 0.
- `mode`, in, 2: `mode_t`. 00 MANUAL, 01 RECORD, 10 PLAYBACK, 11 CLEAR.
- `store_en`, in, 1: write strobe, sampled every edge.
- `sel`, in, IW: slot index for MANUAL write and display.
- `data_in`, in, WIDTH: word to store.
- `led`, out, WIDTH: registered display word.
- `shown_idx`, out, IW: slot currently driving `led`.
- `valid`, out, DEPTH: per-slot written flag.
- `count`, out, CW: number of set `valid` bits.
- `full`, out, 1: `count == DEPTH`.
- `stored`, out, WIDTH*DEPTH: flat memory image. Slot i occupies `[i*WIDTH +: WIDTH]`.

## Operation

Reset (`reset==0`) clears:
- all slots, `valid`, `led`, `shown_idx`
- write pointer `wr_ptr`, last-written pointer `last_ptr`, playback pointer `play_ptr`
- divider

Reset dominates every other input.

MANUAL:
- `store_en=1` writes `data_in` to slot `sel` and sets `valid[sel]`.
- Display index = `sel`.

RECORD:
- `store_en=1` writes to slot `wr_ptr` and sets its valid bit.
- Same edge: `last_ptr<=wr_ptr`, and `wr_ptr` increments mod DEPTH.
- Wrap-around overwrites the oldest slot silently. `count` stays at DEPTH.
- Display index = `last_ptr`.

PLAYBACK:
- `store_en` is ignored; no writes.
- On the first cycle in PLAYBACK (previous mode ≠ 10), `play_ptr<=0` and the divider clears.
- Each divider tick (every PLAY_DIV cycles) does `play_ptr<=play_ptr+1` mod DEPTH.
- Display index = `play_ptr`.

CLEAR:
- Every cycle in this mode clears all slots, `valid`, `wr_ptr`, `last_ptr`.
- `store_en` is ignored.
- Display index = `sel`.

Common rules:
- MANUAL writes do not move `wr_ptr`. Leaving and re-entering RECORD resumes at the current `wr_ptr`.
- Display word = slot contents if that slot's valid bit is set, else 0.
- `count`/`full` are derived combinationally from registered `valid`.

## Timing

- `led` and `shown_idx` are registered from the current memory, `valid` and display index. Latency is 1 cycle.
- A write at edge k updates memory and `valid` at edge k. `led` shows the new word after edge k+1.
- A change of `sel` or mode reaches `led` one edge later.
- Divider: counts 0..PLAY_DIV-1 and pulses `tick` for one cycle at PLAY_DIV-1. The first advance therefore occurs PLAY_DIV cycles after PLAYBACK entry.
- A mode change on the same edge as `store_en`: the mode sampled at that edge governs.
- Reset mid-playback or mid-record: all state returns to reset values at that edge. `led=0` from the next cycle.

## Structure

- `snapshot_pkg`: `mode_t` enum (MANUAL, RECORD, PLAYBACK, CLEAR).
- Sub-module `tick_divider`:
  - parameter `DIV`
  - ports `clk`, `reset`, `clr`, `tick`
  - synchronous active-low reset
  - `clr` zeroes the count.
- Memory: an array of DEPTH × WIDTH registers. No RAM inference required.
- The top level holds the pointers, valid bits and display register.

## Test plan

Run the bench with `PLAY_DIV=4`.

- **Reset:** drive `reset=0` for 2 cycles with `store_en=1`. Expect `led=0`, `valid=0`, `count=0`, `stored=0`.
- **MANUAL:**
  - Stimulus: write 0xA5A5 to `sel=2`.
  - Expect `valid=4'b0100`, `count=1`.
  - Expect `led=0xA5A5` and `shown_idx=2` one cycle after the write edge.
  - Then `sel=1`: expect `led=0`.
- **RECORD wrap:**
  - Stimulus: store 0x0001..0x0005 on consecutive cycles.
  - Expect slot0=0x0005, slot1..3=0x0002..0x0004.
  - Expect `full=1`, `count=4`, `led=0x0005`, `shown_idx=0`.
- **PLAYBACK:**
  - Stimulus: after the wrap test, enter mode 10.
  - Expect `shown_idx` sequence 0,1,2,3,0, advancing every 4 cycles.
  - Expect `led` to follow 0x0005, 0x0002, 0x0003, 0x0004.
  - `store_en` pulses in this mode must leave memory unchanged.
- **CLEAR then RECORD:**
  - Stimulus: one cycle in mode 11, then RECORD store 0x00FF.
  - Expect `count` 0 then 1, `wr_ptr` restarted (slot0=0x00FF), `led=0x00FF`.
- **Reset mid-playback:** assert `reset=0` during mode 10. Expect `shown_idx=0`, `led=0`, `valid=0`. No tick appears until PLAY_DIV cycles after PLAYBACK is re-entered.
